// File: rtl/sc_transi_shifter.sv
// sc_transi_shifter: loads a pattern on start and shifts it once per prescaled tick for a programmed step count.
// Define SC_TRANSISHIFT_ROTATE_EN to make shifts rotations instead of zero-fill logical shifts.
module sc_transi_shifter #(
    parameter int TRANSI_DATAWIDTH  = 8,
    parameter int TRANSI_STEPWIDTH  = 4,
    parameter int TRANSI_PRESCWIDTH = 4,
    parameter int TRANSI_PRESC_MAX  = 9
) (
    input  logic                        SC_TRANSISHIFT_CLOCK_50,
    input  logic                        SC_TRANSISHIFT_RESET_InLow,
    input  logic                        SC_TRANSISHIFT_start_In,
    input  logic                        SC_TRANSISHIFT_dir_In,
    input  logic [TRANSI_STEPWIDTH-1:0] SC_TRANSISHIFT_steps_InBUS,
    input  logic [TRANSI_DATAWIDTH-1:0] SC_TRANSISHIFT_data_InBUS,
    output logic [TRANSI_DATAWIDTH-1:0] SC_TRANSISHIFT_data_OutBUS,
    output logic                        SC_TRANSISHIFT_busy_Out,
    output logic                        SC_TRANSISHIFT_done_Out
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t                       state_q;
    logic [TRANSI_DATAWIDTH-1:0]  data_q, shifted_d;
    logic [TRANSI_STEPWIDTH-1:0]  steps_q, step_q, step_inc_d;
    logic [TRANSI_PRESCWIDTH-1:0] presc_q;
    logic                         dir_q, busy_q, done_q;
    always_comb begin
`ifdef SC_TRANSISHIFT_ROTATE_EN
        shifted_d = dir_q ? {data_q[0], data_q[TRANSI_DATAWIDTH-1:1]}
                          : {data_q[TRANSI_DATAWIDTH-2:0], data_q[TRANSI_DATAWIDTH-1]};
`else
        shifted_d = dir_q ? {1'b0, data_q[TRANSI_DATAWIDTH-1:1]}
                          : {data_q[TRANSI_DATAWIDTH-2:0], 1'b0};
`endif
        step_inc_d = step_q + 1'b1;
    end
    // busy/done are registered alongside the state so they track it exactly
    always_ff @(posedge SC_TRANSISHIFT_CLOCK_50 or negedge SC_TRANSISHIFT_RESET_InLow) begin
        if (!SC_TRANSISHIFT_RESET_InLow) begin
            state_q <= IDLE;
            data_q  <= '0;
            steps_q <= '0;
            step_q  <= '0;
            presc_q <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (SC_TRANSISHIFT_start_In) begin
                    data_q  <= SC_TRANSISHIFT_data_InBUS;
                    dir_q   <= SC_TRANSISHIFT_dir_In;
                    steps_q <= SC_TRANSISHIFT_steps_InBUS;
                    step_q  <= '0;
                    presc_q <= '0;
                    state_q <= (SC_TRANSISHIFT_steps_InBUS == '0) ? DONE : SHIFT;
                    busy_q  <= (SC_TRANSISHIFT_steps_InBUS != '0);
                    done_q  <= (SC_TRANSISHIFT_steps_InBUS == '0);
                end
                SHIFT: if (presc_q == TRANSI_PRESCWIDTH'(TRANSI_PRESC_MAX)) begin
                    presc_q <= '0;
                    data_q  <= shifted_d;
                    step_q  <= step_inc_d;
                    if (step_inc_d == steps_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
    assign SC_TRANSISHIFT_data_OutBUS = data_q;
    assign SC_TRANSISHIFT_busy_Out    = busy_q;
    assign SC_TRANSISHIFT_done_Out    = done_q;
endmodule

// File: doc/sc_transi_shifter.md
# sc_transi_shifter

Upstream source of the transition pattern bus consumed by the CC_MUX10 transition selector. It loads a parallel pattern on a start request, then shifts it one position per prescaled tick for a programmed number of steps, presenting the register continuously on its output bus. It reports busy and issues a one-cycle done pulse, so the game sequencer knows when the transition has finished.

## Interface

- TRANSI_DATAWIDTH, 8: width of the pattern register and output bus; must match the mux TRANSI width.
- TRANSI_STEPWIDTH, 4: width of the step-count input and the internal step counter.
- TRANSI_PRESCWIDTH, 4: width of the prescaler counter.
- TRANSI_PRESC_MAX, 9: prescaler terminal value; one shift every TRANSI_PRESC_MAX+1 clocks. Must fit in TRANSI_PRESCWIDTH.

- SC_TRANSISHIFT_CLOCK_50  in  1  system clock, rising edge.
- SC_TRANSISHIFT_RESET_InLow  in  1  reset, asynchronous, active-low.
- SC_TRANSISHIFT_start_In  in  1  start request, level-sampled each clock; honoured only in IDLE.
- SC_TRANSISHIFT_dir_In  in  1  shift direction: 0 = left (toward MSB), 1 = right (toward LSB); latched at start.
- SC_TRANSISHIFT_steps_InBUS  in  TRANSI_STEPWIDTH  number of shifts; latched at start.
- SC_TRANSISHIFT_data_InBUS  in  TRANSI_DATAWIDTH  pattern loaded at start.
- SC_TRANSISHIFT_data_OutBUS  out  TRANSI_DATAWIDTH  registered pattern; drives the mux TRANSI input.
- SC_TRANSISHIFT_busy_Out  out  1  high while in SHIFT.
- SC_TRANSISHIFT_done_Out  out  1  one-cycle pulse when the sequence completes.

## Operation

- States: IDLE, SHIFT, DONE. Moore outputs: busy = (state == SHIFT); done = (state == DONE).
- IDLE: the register holds its value. When start = 1, load data_OutBUS <= data_InBUS, latch dir and steps, clear the prescaler and step counter. Go to DONE if steps == 0, otherwise go to SHIFT.
- SHIFT: the prescaler counts 0..TRANSI_PRESC_MAX and wraps to 0.
  - At the terminal value, shift the register one position and increment the step counter.
  - When the incremented count equals the latched steps, go to DONE in the same edge.
- DONE: lasts exactly one cycle, then go to IDLE. The register keeps its final value until the next start.
- Shift fill: the vacated bit is 0. Left shifts data in from LSB side; right shifts from MSB side.
- start in SHIFT or DONE is ignored; it has no effect on latched values or counters. A level still high on return to IDLE starts a new sequence.
- Step counter width is TRANSI_STEPWIDTH. The maximum programmable sequence is 2^TRANSI_STEPWIDTH−1 shifts.
- Reset asserted: state goes to IDLE; data_OutBUS, busy, done, prescaler and step counter go to 0, immediately and asynchronously. Release is synchronous to the next clock edge.
- Reset asserted mid-SHIFT aborts the sequence with no done pulse.

## Timing

- Start sampled at edge E0: data_OutBUS shows the loaded pattern, and busy is high, after E0.
- First shift at edge E0 + (TRANSI_PRESC_MAX+1). Shift k occurs at E0 + k·(TRANSI_PRESC_MAX+1).
- done is high for the single cycle after the final shift edge. busy drops on that same final shift edge.
- steps == 0: done is high for the cycle after E0; busy never asserts.
- Earliest re-start is the edge after the done cycle, so back-to-back sequences have a 1-cycle gap.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration

- SC_TRANSISHIFT_ROTATE_EN defined: shifts are rotations. The bit shifted out re-enters at the opposite end, so the pattern is never lost.
- SC_TRANSISHIFT_ROTATE_EN undefined: shifts are logical, with zero fill as above.
- All state, counter and handshake timing is identical in both builds.

## Test plan

All scenarios use default parameters, i.e. 10 clocks per step.

- Reset low for 3 cycles, then release → data_OutBUS = 8'h00, busy = 0, done = 0, state IDLE.
- data = 8'h81, dir = 0, steps = 1, start pulse → data_OutBUS = 8'h81 after E0; 8'h02 at E0+10 (8'h03 with ROTATE_EN). done is high exactly in cycle E0+10..E0+11.
- data = 8'h80, dir = 1, steps = 8 → busy for 80 cycles. Final value is 8'h00 (8'h80 with ROTATE_EN). done pulses once.
- steps = 0, data = 8'h5A → data_OutBUS = 8'h5A, busy never high, done is high in the cycle after E0.
- During SHIFT (dir = 0, steps = 4, data = 8'h01), assert start with data = 8'hFF, dir = 1, steps = 1 → ignored. The final value is 8'h10, with done at E0+40.
- Reset low at E0+25 of an 8-step sequence → outputs go to 0 asynchronously, no done pulse. A subsequent start behaves as a fresh sequence.
